// File: rtl/s1_8_align.sv
// s1_8_align -- serial-to-parallel receive stage with comma alignment.
//
// Shifts the 1-bit line stream in MSB first on clk_32f, hunts for the COM
// symbol, counts LOCK_COUNT boundary-aligned COMs to declare lock, then
// presents each aligned byte on data_out for a full byte period (8 clk_32f
// cycles) so the clk_4f packer downstream samples it cleanly.
//
// Ports:
//   clk_32f      in   bit clock, 8x the byte rate
//   reset        in   synchronous, active-high
//   data_serial  in   serial line bit, MSB of each byte first
//   data_out     out  [7:0] aligned byte, updated only at byte boundaries while locked
//   valid_out    out  high while data_out holds a non-COM byte
//   active       out  high while locked
//
// Optional feature macro: S1_8_RELOCK_EN
//   defined   -> a misaligned COM while locked drops lock and restarts
//                alignment from that comma
//   undefined -> lock is sticky until reset
//
// state     | meaning
// ----------+------------------------------------------------------------
// UNLOCKED  | hunting for a COM at any bit position, bit_cnt held at 0
// ALIGNING  | COM seen, counting consecutive boundary-aligned COMs
// LOCKED    | aligned; latch each byte at the boundary, active=1

module s1_8_align #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_serial,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ALIGNING,
    ST_LOCKED
  } state_t;

  localparam logic [3:0] LOCK_CNT = LOCK_COUNT[3:0];

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  com_cnt_q, com_cnt_d;
  // Only the 7 most recent past bits are ever needed: the window is those
  // plus the bit on the line this cycle.
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;

  logic [7:0]  window;
  logic        boundary;
  logic        is_com;
  logic [3:0]  com_inc;

  assign window   = {shift_q, data_serial};
  assign boundary = (bit_cnt_q == 3'd7);
  assign is_com   = (window == COM_SYMBOL);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = (state_q == ST_UNLOCKED) ? 3'd0 : bit_cnt_q + 3'd1;
    com_cnt_d = com_cnt_q;
    shift_d   = window[6:0];
    data_d    = data_q;
    valid_d   = valid_q;
    com_inc   = com_cnt_q + 4'd1;

    case (state_q)
      ST_UNLOCKED: begin
        if (is_com) begin
          // This comma defines the boundary: bit_cnt reaches 7 exactly
          // eight cycles later.
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          state_d   = (LOCK_CNT == 4'd1) ? ST_LOCKED : ST_ALIGNING;
        end
      end

      ST_ALIGNING: begin
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_inc;
            if (com_inc == LOCK_CNT) begin
              state_d = ST_LOCKED;
            end
          end else begin
            // bit_cnt wraps 7->0 here, which is also its UNLOCKED hold value.
            state_d   = ST_UNLOCKED;
            com_cnt_d = 4'd0;
          end
        end
      end

      ST_LOCKED: begin
        if (boundary) begin
          data_d  = window;
          valid_d = !is_com;
        end
`ifdef S1_8_RELOCK_EN
        else if (is_com) begin
          // Misaligned comma: treat it as a fresh first COM; data_out keeps
          // the last delivered byte.
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          valid_d   = 1'b0;
          state_d   = (LOCK_CNT == 4'd1) ? ST_LOCKED : ST_ALIGNING;
        end
`endif
      end

      default: begin
        state_d   = ST_UNLOCKED;
        bit_cnt_d = 3'd0;
        com_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= ST_UNLOCKED;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      shift_q   <= 7'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_s1_8_align.sv
// Testbench for s1_8_align: directed scenarios plus a randomized stream,
// all checked every cycle against a behavioural model that tracks alignment
// as an absolute cycle anchor (boundaries every 8 cycles after the comma).

module tb_s1_8_align;

  localparam logic [7:0] COM  = 8'hBC;
  localparam int         LOCK = 4;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_serial;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int errors = 0;
  int checks = 0;

  // behavioural model
  logic [7:0] m_hist;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_locked;
  logic       m_counting;
  int         m_cnt;
  longint     m_t = 0;
  longint     m_anchor = 0;

  s1_8_align #(.COM_SYMBOL(8'hBC), .LOCK_COUNT(4)) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_serial (data_serial),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active      (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic start_align();
    m_anchor   = m_t;
    m_cnt      = 1;
    m_locked   = (LOCK == 1);
    m_counting = (LOCK != 1);
  endtask

  task automatic model_edge(input logic rst, input logic b);
    logic [7:0] win;
    logic       on_grid;
    m_t++;
    if (rst) begin
      m_hist = 8'h00; m_data = 8'h00; m_valid = 1'b0;
      m_locked = 1'b0; m_counting = 1'b0; m_cnt = 0;
    end else begin
      win     = {m_hist[6:0], b};
      m_hist  = win;
      on_grid = (m_locked || m_counting) && (((m_t - m_anchor) % 8) == 0);
      if (m_locked) begin
        if (on_grid) begin
          m_data  = win;
          m_valid = (win != COM);
        end
`ifdef S1_8_RELOCK_EN
        else if (win == COM) begin
          m_valid = 1'b0;
          start_align();
        end
`endif
      end else if (m_counting) begin
        if (on_grid) begin
          if (win == COM) begin
            m_cnt++;
            if (m_cnt == LOCK) begin
              m_locked   = 1'b1;
              m_counting = 1'b0;
            end
          end else begin
            m_counting = 1'b0;
            m_cnt      = 0;
          end
        end
      end else if (win == COM) begin
        start_align();
      end
    end
  endtask

  // Drive one bit, advance one edge, compare DUT against the model.
  task automatic step(input logic rst, input logic b);
    reset       = rst;
    data_serial = b;
    model_edge(rst, b);
    @(posedge clk_32f);
    #1;
    checks++;
    if ({data_out, valid_out, active} !== {m_data, m_valid, m_locked}) begin
      errors++;
      $display("FAIL model t=%0d: got data=%h valid=%b active=%b, want data=%h valid=%b active=%b",
               m_t, data_out, valid_out, active, m_data, m_valid, m_locked);
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(1'b0, v[i]);
  endtask

  task automatic rand_bits(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  initial begin
    logic [7:0] b;
    int r;
    reset = 1'b1;
    data_serial = 1'b0;

    // 1: reset with random data
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
    check_lit("rst_data", data_out, 8'h00);
    check_lit("rst_valid", {7'd0, valid_out}, 8'h00);
    check_lit("rst_active", {7'd0, active}, 8'h00);

    // 2: random preamble, 4 COMs, two data bytes
    rand_bits(3);
    check_lit("pre_active", {7'd0, active}, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(COM);
    check_lit("com3_active", {7'd0, active}, 8'h00);
    send_byte(COM);
    check_lit("com4_active", {7'd0, active}, 8'h01);
    check_lit("lock_no_data", {7'd0, valid_out}, 8'h00);
    send_byte(8'hA5);
    check_lit("a5_data", data_out, 8'hA5);
    check_lit("a5_valid", {7'd0, valid_out}, 8'h01);
    for (int i = 7; i >= 1; i--) step(1'b0, 1'(8'h3C >> i));
    check_lit("a5_hold", data_out, 8'hA5);
    step(1'b0, 1'b0);
    check_lit("3c_data", data_out, 8'h3C);

    // 3: COM inside locked stream
    send_byte(8'hA5);
    send_byte(COM);
    check_lit("bc_data", data_out, 8'hBC);
    check_lit("bc_valid", {7'd0, valid_out}, 8'h00);
    send_byte(8'h7E);
    check_lit("7e_data", data_out, 8'h7E);
    check_lit("7e_valid", {7'd0, valid_out}, 8'h01);
    for (int i = 0; i < 20; i++) send_byte(8'($urandom_range(0, 255)));

    // 5: reset mid-byte
    rand_bits(3);
    step(1'b1, 1'($urandom_range(0, 1)));
    check_lit("midrst_data", data_out, 8'h00);
    check_lit("midrst_active", {7'd0, active}, 8'h00);
    send_byte(8'h5A);
    check_lit("midrst_nodata", {7'd0, valid_out}, 8'h00);
    for (int i = 0; i < 4; i++) send_byte(COM);
    send_byte(8'h66);
    check_lit("relock_66", data_out, 8'h66);

    // 4: broken alignment then re-lock
    step(1'b1, 1'b0);
    send_byte(COM); send_byte(COM); send_byte(8'h11);
    check_lit("drop_active", {7'd0, active}, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(COM);
    check_lit("realign_active", {7'd0, active}, 8'h00);
    send_byte(COM);
    check_lit("relock_active", {7'd0, active}, 8'h01);
    send_byte(8'h22);
    check_lit("22_data", data_out, 8'h22);
    check_lit("22_valid", {7'd0, valid_out}, 8'h01);

    // 6: misaligned comma (shifted by 3 bits)
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    send_byte(COM);
    check_lit("slip_data", data_out, 8'h17);
`ifdef S1_8_RELOCK_EN
    check_lit("slip_active", {7'd0, active}, 8'h00);
    check_lit("slip_valid", {7'd0, valid_out}, 8'h00);
`else
    check_lit("slip_active", {7'd0, active}, 8'h01);
    check_lit("slip_valid", {7'd0, valid_out}, 8'h01);
`endif
    for (int i = 0; i < 3; i++) send_byte(COM);
    check_lit("slip_after", {7'd0, active}, 8'h01);

    // randomized stream: commas, data, bit slips, occasional reset
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       step(1'b1, 1'($urandom_range(0, 1)));
      else if (r < 35) send_byte(COM);
      else if (r < 42) rand_bits($urandom_range(1, 7));
      else begin
        b = 8'($urandom_range(0, 255));
        send_byte(b);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/s1_8_align.md
Name: s1_8_align

Overview:
- Serial-to-parallel receive stage with symbol alignment.
- Runs on clk_32f and takes the 1-bit line stream, MSB first.
- Finds byte boundaries by locking onto repeated COM symbols (0xBC), then delivers aligned 8-bit bytes with a valid flag to the 8-to-32 packer downstream.
- Each output byte is held stable for 8 clk_32f cycles, so the clk_4f consumer samples it cleanly.

Parameters:
COM_SYMBOL, 8'hBC, idle/alignment symbol; never delivered as valid data
LOCK_COUNT, 4, consecutive boundary-aligned COMs required to declare lock (legal range 1..15)

Ports:
clk_32f  input  1  bit clock, 8x the byte rate
reset  input  1  synchronous, active-high
data_serial  input  1  serial line bit, MSB of each byte first
data_out  output  8  aligned byte, updated only at byte boundaries while locked
valid_out  output  1  high while data_out holds a non-COM byte
active  output  1  high while in LOCKED

Behaviour:
- One clock (clk_32f). Reset is synchronous and active-high; it is sampled on the rising edge and overrides everything else.
- Reset values:
  - data_out=0, valid_out=0, active=0
  - state=UNLOCKED, bit_cnt=0, com_cnt=0, shift=0
- Shifting and window:
  - Every cycle: shift <= {shift[6:0], data_serial}.
  - window = {shift[6:0], data_serial} (combinational). It is the 8 most recent bits including the current one.
- bit_cnt:
  - 3-bit counter, increments every cycle outside UNLOCKED, wraps 7->0.
  - bit_cnt==7 marks a byte boundary (window is a complete aligned byte).
- UNLOCKED:
  - bit_cnt is held at 0.
  - Any cycle with window==COM_SYMBOL: bit_cnt<=0, com_cnt<=1.
  - Next state is ALIGNING, or LOCKED directly if LOCK_COUNT==1.
- ALIGNING:
  - At a boundary with window==COM: com_cnt<=com_cnt+1. If com_cnt+1==LOCK_COUNT, go to LOCKED and set active<=1.
  - At a boundary with window!=COM: go to UNLOCKED, com_cnt<=0.
  - A COM detected at a non-boundary position is ignored.
  - data_out and valid_out are not updated in this state.
- LOCKED, at each boundary:
  - data_out<=window.
  - valid_out<=(window!=COM_SYMBOL).
  - The pair holds until the next boundary.
  - First data update happens at the boundary following the lock-achieving COM.
- Latency: last bit of a byte sampled at edge k. That byte appears on data_out/valid_out after edge k (registered), stable for edges k+1..k+8.
- Lock is sticky until reset (see Optional Feature).
- Reset mid-operation: the next edge returns all state and outputs to reset values. The partially shifted byte is discarded, and alignment restarts from UNLOCKED.
- Simultaneous events: reset beats everything. The lock decision and the first data update never occur on the same edge.

Optional Feature:
- Macro: S1_8_RELOCK_EN
- Defined:
  - In LOCKED, a cycle with window==COM at bit_cnt!=7 (misaligned comma) forces UNLOCKED.
  - On that edge: active<=0, valid_out<=0, com_cnt<=1, bit_cnt<=0, then continue in ALIGNING from that comma (same as the UNLOCKED COM detection).
  - data_out keeps its last value.
- Undefined:
  - Misaligned commas in LOCKED are ignored.
  - LOCKED exits only via reset.

Test Plan:
1. Reset held 3 cycles with random data_serial -> data_out=0x00, valid_out=0, active=0 throughout; release -> still 0 until alignment.
2. 3 random bits, then BC BC BC BC, then 0xA5 0x3C -> active=1 after the 4th BC's last bit; data_out=0xA5 with valid_out=1 for 8 cycles, then 0x3C with valid_out=1.
3. Locked stream A5 BC 7E -> valid_out 1,0,1 per byte window; data_out shows BC during the invalid window.
4. BC BC 11 BC BC BC BC 22 -> the 0x11 boundary drops to UNLOCKED (active stays 0); re-lock after the following four BCs; then data_out=0x22 with valid_out=1.
5. Locked, then reset asserted mid-byte for 1 cycle -> outputs 0 on the next edge; a new BC x4 sequence is required before data resumes.
6. With S1_8_RELOCK_EN: locked, then a BC inserted shifted by 3 bits -> active=0 and valid_out=0 on the detecting edge; three more aligned BCs restore active=1. Without the macro: active stays 1.
